tx_cp_insert_pingpong: RTL and testbench

Parametrised successor to the IFFT-output/cyclic-prefix stage of the OFDM TX chain. It accepts the wide IFFT output one sample per cycle, then does three things:
- rounds-by-truncation and saturates each sample to OUT_W bits;
- buffers whole symbols in a two-bank ping-pong RAM;
- emits each symbol with a runtime-selectable cyclic prefix.

It sits between the IFFT core and the TX sample FIFO/DAC interface, supports back-to-back symbols and output backpressure.

---
 rtl/tx_cp_insert_pingpong.sv | 212 +++++++++++++++++++++
 tb/tb_tx_cp_insert_pingpong.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_cp_insert_pingpong.sv
// IFFT output saturation, two-bank ping-pong symbol buffer and cyclic-prefix insertion.
// Define TX_CP_SAT_STATUS_EN to add the sat_flag / sat_cnt status outputs.
module tx_cp_insert_pingpong #(
   parameter int unsigned NFFT   = 128,
   parameter int unsigned CP_MAX = 32,
   parameter int unsigned IN_W   = 40,
   parameter int unsigned OUT_W  = 16,
   parameter int unsigned SHIFT  = 22,
   localparam int unsigned AW    = $clog2(NFFT),
   localparam int unsigned CW    = $clog2(CP_MAX + 1)
) (
   input  logic             clk_Modulation,
   input  logic             reset,
   input  logic [CW-1:0]    cp_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_re,
   input  logic [IN_W-1:0]  in_im,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_re,
   output logic [OUT_W-1:0] out_im,
   output logic             out_first,
   output logic             out_last,
   output logic [15:0]      sym_cnt
`ifdef TX_CP_SAT_STATUS_EN
   ,
   output logic             sat_flag,
   output logic [15:0]      sat_cnt
`endif
);

   typedef enum logic [1:0] {StIdle, StPrefix, StBody} rd_state_e;

   function automatic logic hi_ok(input logic [IN_W-1:0] x);
      hi_ok = (&x[IN_W-1:SHIFT+OUT_W-1]) || ~(|x[IN_W-1:SHIFT+OUT_W-1]);
   endfunction

   function automatic logic [OUT_W-1:0] conv(input logic signed [IN_W-1:0] x);
      logic signed [IN_W-1:0] v;
      v = x >>> SHIFT;
      if (hi_ok(x)) conv = v[OUT_W-1:0];
      else          conv = {x[IN_W-1], {(OUT_W-1){~x[IN_W-1]}}};
   endfunction

   logic [2*OUT_W-1:0] mem [2*NFFT];
   logic [2*OUT_W-1:0] ram_q;

   logic          wr_bank, rd_bank;
   logic [AW-1:0] wr_idx, rd_idx;
   logic [1:0]    full, full_set, full_clr;
   logic          wr_fire, wr_done, rel, issue;
   rd_state_e     state;
   logic [CW-1:0] cp_eff, cp_sel;
   rd_state_e     start_state;
   logic [AW-1:0] start_idx;
   logic          other_full, is_first, is_last;
   logic          rd_pend, pend_first, pend_last;
   logic          skid_valid, pop;
   logic [2*OUT_W+1:0] skid_w, pipe_w;
   logic [1:0]    occ;

   assign in_ready = !full[wr_bank];
   assign wr_fire  = in_valid && in_ready;
   assign wr_done  = wr_fire && (wr_idx == AW'(NFFT - 1));

   always_comb begin
      full_set = '0;
      full_clr = '0;
      full_set[wr_bank] = wr_done;
      full_clr[rd_bank] = rel;
   end

   always_ff @(posedge clk_Modulation or posedge reset) begin
      if (reset) begin
         wr_bank <= 1'b0;
         wr_idx  <= '0;
         full    <= '0;
      end else begin
         if (wr_fire) begin
            wr_idx <= wr_done ? '0 : wr_idx + 1'b1;
            if (wr_done) wr_bank <= ~wr_bank;
         end
         full <= (full & ~full_clr) | full_set;
      end
   end

   always_ff @(posedge clk_Modulation) begin
      if (wr_fire) mem[{wr_bank, wr_idx}] <= {conv(in_re), conv(in_im)};
      if (issue)   ram_q <= mem[{rd_bank, rd_idx}];
   end

   // Reads are issued only when the output register, skid slot and in-flight read leave room.
   assign pop   = out_valid && out_ready;
   assign occ   = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pend) - 2'(pop);
   assign issue = (state != StIdle) && (occ < 2'd2);

   assign cp_sel      = (cp_len > CW'(CP_MAX)) ? CW'(CP_MAX) : cp_len;
   assign start_state = (cp_sel != '0) ? StPrefix : StBody;
   assign start_idx   = AW'(0) - AW'(cp_sel);
   // A fill of the other bank landing this cycle still counts, so back-to-back stays gapless.
   assign other_full  = full[!rd_bank] || (wr_done && (wr_bank != rd_bank));
   assign is_last     = (state == StBody) && (rd_idx == AW'(NFFT - 1));
   assign is_first    = ((state == StPrefix) && (rd_idx == AW'(0) - AW'(cp_eff))) ||
                        ((state == StBody) && (rd_idx == '0) && (cp_eff == '0));
   assign rel         = issue && is_last;

   always_ff @(posedge clk_Modulation or posedge reset) begin
      if (reset) begin
         state      <= StIdle;
         rd_bank    <= 1'b0;
         rd_idx     <= '0;
         cp_eff     <= '0;
         rd_pend    <= 1'b0;
         pend_first <= 1'b0;
         pend_last  <= 1'b0;
      end else begin
         rd_pend <= issue;
         if (issue) begin
            pend_first <= is_first;
            pend_last  <= is_last;
         end
         unique case (state)
            StIdle: begin
               if (full[rd_bank]) begin
                  state  <= start_state;
                  rd_idx <= start_idx;
                  cp_eff <= cp_sel;
               end
            end
            StPrefix: begin
               if (issue) begin
                  if (rd_idx == AW'(NFFT - 1)) begin
                     state  <= StBody;
                     rd_idx <= '0;
                  end else begin
                     rd_idx <= rd_idx + 1'b1;
                  end
               end
            end
            StBody: begin
               if (issue) begin
                  if (is_last) begin
                     rd_bank <= ~rd_bank;
                     if (other_full) begin
                        state  <= start_state;
                        rd_idx <= start_idx;
                        cp_eff <= cp_sel;
                     end else begin
                        state <= StIdle;
                     end
                  end else begin
                     rd_idx <= rd_idx + 1'b1;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign pipe_w = {pend_first, pend_last, ram_q};

   always_ff @(posedge clk_Modulation or posedge reset) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_first  <= 1'b0;
         out_last   <= 1'b0;
         out_re     <= '0;
         out_im     <= '0;
         skid_valid <= 1'b0;
         skid_w     <= '0;
         sym_cnt    <= '0;
      end else begin
         if (pop && out_last) sym_cnt <= sym_cnt + 16'd1;
         if (!out_valid || out_ready) begin
            if (skid_valid) begin
               out_valid <= 1'b1;
               {out_first, out_last, out_re, out_im} <= skid_w;
               skid_valid <= rd_pend;
               if (rd_pend) skid_w <= pipe_w;
            end else if (rd_pend) begin
               out_valid <= 1'b1;
               {out_first, out_last, out_re, out_im} <= pipe_w;
            end else begin
               out_valid <= 1'b0;
               out_first <= 1'b0;
               out_last  <= 1'b0;
            end
         end else if (rd_pend) begin
            skid_valid <= 1'b1;
            skid_w     <= pipe_w;
         end
      end
   end

`ifdef TX_CP_SAT_STATUS_EN
   logic sat_hit;
   assign sat_hit = wr_fire && (!hi_ok(in_re) || !hi_ok(in_im));

   always_ff @(posedge clk_Modulation or posedge reset) begin
      if (reset) begin
         sat_flag <= 1'b0;
         sat_cnt  <= '0;
      end else begin
         sat_flag <= sat_hit;
         if (sat_hit && (sat_cnt != 16'hFFFF)) sat_cnt <= sat_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tx_cp_insert_pingpong.sv
// Directed bench for tx_cp_insert_pingpong: framing, saturation, streaming, backpressure, reset.
`timescale 1ns/1ps
module tb_tx_cp_insert_pingpong;
   localparam int NFFT  = 128;
   localparam int SHIFT = 22;

   logic        clk_Modulation = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  cp_len = 6'd32;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [39:0] in_re = '0, in_im = '0;
   logic        out_valid, out_ready = 1'b1;
   logic [15:0] out_re, out_im;
   logic        out_first, out_last;
   logic [15:0] sym_cnt;
`ifdef TX_CP_SAT_STATUS_EN
   logic        sat_flag;
   logic [15:0] sat_cnt;
`endif

   tx_cp_insert_pingpong dut (
      .clk_Modulation(clk_Modulation), .reset(reset), .cp_len(cp_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
      .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
      .out_first(out_first), .out_last(out_last), .sym_cnt(sym_cnt)
`ifdef TX_CP_SAT_STATUS_EN
      , .sat_flag(sat_flag), .sat_cnt(sat_cnt)
`endif
   );

   always #5 clk_Modulation = ~clk_Modulation;

   int checks = 0, passes = 0;
   int cyc = 0, stall_cnt = 0;
   logic tmo = 1'b0, abort = 1'b0;
   logic [33:0] cap_q[$];
   int cap_t[$];
   logic        ov_en [NFFT];
   logic [39:0] ov_re [NFFT];
   logic [39:0] ov_im [NFFT];

   always @(posedge clk_Modulation) cyc <= cyc + 1;

   always @(negedge clk_Modulation) begin
      if (!reset && out_valid && out_ready) begin
         cap_q.push_back({out_first, out_last, out_re, out_im});
         cap_t.push_back(cyc);
      end
      if (!reset && in_valid && !in_ready) stall_cnt <= stall_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [33:0] exp_word(input int s, input int cp, input int j);
      int idx, val;
      idx = (j < cp) ? NFFT - cp + j : j - cp;
      val = s * NFFT + idx;
      return {(j == 0), (j == cp + NFFT - 1), 16'(val), 16'(-val)};
   endfunction

   function automatic int first_bad(input int base, input int s, input int cp);
      for (int j = 0; j < cp + NFFT; j++) begin
         if (base + j >= cap_q.size()) return j;
         if (cap_q[base + j] !== exp_word(s, cp, j)) return j;
      end
      return -1;
   endfunction

   task automatic send_symbol(input int s);
      int guard;
      for (int i = 0; i < NFFT; i++) begin
         in_valid = 1'b1;
         if (ov_en[i]) begin
            in_re = ov_re[i];
            in_im = ov_im[i];
         end else begin
            in_re = 40'(s * NFFT + i) << SHIFT;
            in_im = -(40'(s * NFFT + i) << SHIFT);
         end
         guard = 0;
         do begin
            @(negedge clk_Modulation);
            guard++;
         end while (!in_ready && guard < 4000 && !abort);
         if (abort || guard >= 4000) begin
            if (!abort) tmo = 1'b1;
            in_valid = 1'b0;
            return;
         end
         @(posedge clk_Modulation);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_caps(input int n);
      int g = 0;
      while (cap_q.size() < n && g < 5000) begin
         @(negedge clk_Modulation);
         g++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0;
      out_ready = 1'b1; cp_len = 6'd32; abort = 1'b0; tmo = 1'b0;
      for (int i = 0; i < NFFT; i++) ov_en[i] = 1'b0;
      repeat (3) @(posedge clk_Modulation);
      #1 reset = 1'b0;
      cap_q.delete(); cap_t.delete(); stall_cnt = 0;
      @(posedge clk_Modulation);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passes++;
      checks++; if (out_first !== 1'b0) $display("FAIL rst_out_first: got %b want 0", out_first); else passes++;
      checks++; if (out_last !== 1'b0) $display("FAIL rst_out_last: got %b want 0", out_last); else passes++;
      checks++; if (out_re !== 16'h0) $display("FAIL rst_out_re: got %h want 0", out_re); else passes++;
      checks++; if (out_im !== 16'h0) $display("FAIL rst_out_im: got %h want 0", out_im); else passes++;
      checks++; if (sym_cnt !== 16'h0) $display("FAIL rst_sym_cnt: got %0d want 0", sym_cnt); else passes++;
      do_reset();
      checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else passes++;
      checks++; if (out_valid !== 1'b0) $display("FAIL rst_idle_valid: got %b want 0", out_valid); else passes++;
   endtask

   task automatic test_single();
      int lat, fb;
      do_reset();
      send_symbol(0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk_Modulation);
         #1;
         lat++;
      end
      checks++; if (lat > 3) $display("FAIL single_latency: got %0d cycles want <=3", lat); else passes++;
      wait_caps(160);
      repeat (5) @(posedge clk_Modulation);
      checks++; if (cap_q.size() !== 160) $display("FAIL single_count: got %0d want 160", cap_q.size()); else passes++;
      fb = first_bad(0, 0, 32);
      checks++; if (fb !== -1) $display("FAIL single_data: first bad sample %0d want none", fb); else passes++;
      checks++; if (cap_q[0] !== {2'b10, 16'd96, 16'hFFA0}) $display("FAIL single_first: got %h want %h", cap_q[0], {2'b10, 16'd96, 16'hFFA0}); else passes++;
      checks++; if (cap_q[159] !== {2'b01, 16'd127, 16'hFF81}) $display("FAIL single_last: got %h want %h", cap_q[159], {2'b01, 16'd127, 16'hFF81}); else passes++;
      checks++; if (sym_cnt !== 16'd1) $display("FAIL single_sym_cnt: got %0d want 1", sym_cnt); else passes++;
   endtask

   task automatic test_saturation();
      logic [31:0] want [5];
      do_reset();
      cp_len = 6'd0;
      for (int i = 5; i < 10; i++) ov_en[i] = 1'b1;
      ov_re[5] = 40'h7F_FFFF_FFFF;          ov_im[5] = 40'h80_0000_0000;
      ov_re[6] = 40'(32767) << SHIFT;       ov_im[6] = -(40'(32768) << SHIFT);
      ov_re[7] = 40'(32768) << SHIFT;       ov_im[7] = -(40'(32769) << SHIFT);
      ov_re[8] = 40'h00_003F_FFFF;          ov_im[8] = 40'hFF_FFFF_FFFF;
      ov_re[9] = -(40'(1) << SHIFT) - 40'd1; ov_im[9] = (40'(5) << SHIFT) | 40'h3F_FFFF;
      want[0] = {16'h7FFF, 16'h8000};
      want[1] = {16'h7FFF, 16'h8000};
      want[2] = {16'h7FFF, 16'h8000};
      want[3] = {16'h0000, 16'hFFFF};
      want[4] = {16'hFFFE, 16'h0005};
      send_symbol(1);
      wait_caps(128);
      repeat (5) @(posedge clk_Modulation);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (cap_q[5 + k][31:0] !== want[k])
            $display("FAIL sat_idx%0d: got %h want %h", 5 + k, cap_q[5 + k][31:0], want[k]);
         else passes++;
      end
      checks++; if (cap_q[10] !== exp_word(1, 0, 10)) $display("FAIL sat_neighbour: got %h want %h", cap_q[10], exp_word(1, 0, 10)); else passes++;
`ifdef TX_CP_SAT_STATUS_EN
      checks++; if (sat_cnt !== 16'd2) $display("FAIL sat_cnt: got %0d want 2", sat_cnt); else passes++;
`endif
   endtask

   task automatic test_back_to_back();
      int gaps, fb;
      do_reset();
      fork
         for (int s = 0; s < 4; s++) send_symbol(s);
         wait_caps(640);
      join
      repeat (5) @(posedge clk_Modulation);
      checks++; if (cap_q.size() !== 640) $display("FAIL b2b_count: got %0d want 640", cap_q.size()); else passes++;
      for (int s = 0; s < 4; s++) begin
         fb = first_bad(s * 160, s, 32);
         checks++; if (fb !== -1) $display("FAIL b2b_data_sym%0d: first bad sample %0d want none", s, fb); else passes++;
      end
      gaps = 0;
      for (int j = 0; j + 1 < cap_t.size(); j++) if (cap_t[j + 1] - cap_t[j] != 1) gaps++;
      checks++; if (gaps !== 0) $display("FAIL b2b_gaps: got %0d want 0", gaps); else passes++;
      checks++; if (stall_cnt == 0) $display("FAIL b2b_in_stall: got %0d stall cycles want >0", stall_cnt); else passes++;
      checks++; if (tmo !== 1'b0) $display("FAIL b2b_timeout: got %b want 0", tmo); else passes++;
      checks++; if (sym_cnt !== 16'd4) $display("FAIL b2b_sym_cnt: got %0d want 4", sym_cnt); else passes++;
   endtask

   task automatic test_backpressure();
      int unstable = 0, stalls = 0, fb;
      do_reset();
      fork
         send_symbol(0);
         begin
            int k = 0;
            while (cap_q.size() < 160 && k < 3000) begin
               out_ready = !((k % 4 == 1) || (k % 4 == 2));
               @(posedge clk_Modulation);
               #1;
               k++;
            end
            out_ready = 1'b1;
         end
         begin
            int g = 0;
            logic stall_prev = 1'b0;
            logic [34:0] held = '0;
            while (cap_q.size() < 160 && g < 3000) begin
               @(negedge clk_Modulation);
               if (stall_prev && ({out_valid, out_first, out_last, out_re, out_im} !== held))
                  unstable++;
               stall_prev = out_valid && !out_ready;
               if (stall_prev) stalls++;
               held = {out_valid, out_first, out_last, out_re, out_im};
               g++;
            end
         end
      join
      repeat (5) @(posedge clk_Modulation);
      checks++; if (cap_q.size() !== 160) $display("FAIL bp_count: got %0d want 160", cap_q.size()); else passes++;
      fb = first_bad(0, 0, 32);
      checks++; if (fb !== -1) $display("FAIL bp_data: first bad sample %0d want none", fb); else passes++;
      checks++; if (unstable !== 0) $display("FAIL bp_stable: got %0d changes want 0", unstable); else passes++;
      checks++; if (stalls == 0) $display("FAIL bp_stalls_seen: got %0d want >0", stalls); else passes++;
      checks++; if (sym_cnt !== 16'd1) $display("FAIL bp_sym_cnt: got %0d want 1", sym_cnt); else passes++;
   endtask

   task automatic test_cp_lengths();
      int fb;
      do_reset();
      cp_len = 6'd0;
      send_symbol(0);
      fork
         send_symbol(1);
         begin
            wait_caps(1);
            cp_len = 6'd40;
            wait_caps(288);
         end
      join
      repeat (5) @(posedge clk_Modulation);
      checks++; if (cap_q.size() !== 288) $display("FAIL cp_count: got %0d want 288", cap_q.size()); else passes++;
      fb = first_bad(0, 0, 0);
      checks++; if (fb !== -1) $display("FAIL cp0_data: first bad sample %0d want none", fb); else passes++;
      checks++; if (cap_q[0][33:32] !== 2'b10) $display("FAIL cp0_first: got %b want 10", cap_q[0][33:32]); else passes++;
      fb = first_bad(128, 1, 32);
      checks++; if (fb !== -1) $display("FAIL cp40_data: first bad sample %0d want none", fb); else passes++;
      checks++; if (sym_cnt !== 16'd2) $display("FAIL cp_sym_cnt: got %0d want 2", sym_cnt); else passes++;
   endtask

   task automatic test_async_reset();
      int fb;
      do_reset();
      send_symbol(0);
      fork
         send_symbol(1);
         begin
            wait_caps(83);
            #1 reset = 1'b1;
            abort = 1'b1;
            #1;
            checks++; if (out_valid !== 1'b0) $display("FAIL arst_valid: got %b want 0", out_valid); else passes++;
            checks++; if ({out_first, out_last} !== 2'b00) $display("FAIL arst_flags: got %b want 00", {out_first, out_last}); else passes++;
            checks++; if ({out_re, out_im} !== 32'h0) $display("FAIL arst_data: got %h want 0", {out_re, out_im}); else passes++;
            checks++; if (sym_cnt !== 16'd0) $display("FAIL arst_sym_cnt: got %0d want 0", sym_cnt); else passes++;
         end
      join
      repeat (3) @(posedge clk_Modulation);
      #1 reset = 1'b0;
      abort = 1'b0;
      cap_q.delete(); cap_t.delete();
      @(posedge clk_Modulation);
      #1;
      checks++; if (in_ready !== 1'b1) $display("FAIL arst_in_ready: got %b want 1", in_ready); else passes++;
      checks++; if (out_valid !== 1'b0) $display("FAIL arst_idle: got %b want 0", out_valid); else passes++;
      send_symbol(2);
      wait_caps(160);
      repeat (5) @(posedge clk_Modulation);
      checks++; if (cap_q.size() !== 160) $display("FAIL arst_count: got %0d want 160", cap_q.size()); else passes++;
      fb = first_bad(0, 2, 32);
      checks++; if (fb !== -1) $display("FAIL arst_data_after: first bad sample %0d want none", fb); else passes++;
      checks++; if (sym_cnt !== 16'd1) $display("FAIL arst_sym_cnt_after: got %0d want 1", sym_cnt); else passes++;
   endtask

   initial begin
      for (int i = 0; i < NFFT; i++) begin
         ov_en[i] = 1'b0;
         ov_re[i] = '0;
         ov_im[i] = '0;
      end
      test_reset();
      test_single();
      test_saturation();
      test_back_to_back();
      test_backpressure();
      test_cp_lengths();
      test_async_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
